// File: rtl/snp_req_ctrl_mc.sv
// Multi-cycle snoop-request controller: tag lookup, L1 invalidate/fetch fan-out with ack
// collection, optional downstream writeback, tag update and snoop response, with per-phase timeout.
module snp_req_ctrl_mc #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_L1      = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sureq_valid,
  output logic                  sureq_ready,
  input  logic [1:0]            sureq_op,
  input  logic [ADDR_WIDTH-1:0] sureq_addr,
  output logic                  tag_rd_en,
  output logic [ADDR_WIDTH-1:0] tag_rd_addr,
  input  logic [2:0]            tag_rd_st,
  input  logic [NUM_L1-1:0]     tag_rd_l1_vec,
  output logic [NUM_L1-1:0]     cureq_valid,
  input  logic [NUM_L1-1:0]     cureq_ready,
  output logic [1:0]            cureq_op,
  output logic [ADDR_WIDTH-1:0] cureq_addr,
  input  logic [NUM_L1-1:0]     cursp_valid,
  input  logic [NUM_L1-1:0]     cursp_dirty,
  output logic                  sdreq_valid,
  input  logic                  sdreq_ready,
  output logic [2:0]            sdreq_op,
  output logic [ADDR_WIDTH-1:0] sdreq_addr,
  input  logic                  sdrsp_valid,
  output logic                  tag_wr_en,
  output logic [ADDR_WIDTH-1:0] tag_wr_addr,
  output logic [2:0]            tag_wr_st,
  output logic [NUM_L1-1:0]     tag_wr_l1_vec,
  output logic                  sursp_valid,
  input  logic                  sursp_ready,
  output logic [1:0]            sursp_rsp,
  output logic                  timeout_err
);

  localparam logic [1:0] SUREQ_RD  = 2'd0;
  localparam logic [1:0] SUREQ_RFO = 2'd1;
  localparam logic [1:0] CUREQ_RD  = 2'd0;
  localparam logic [1:0] CUREQ_RFO = 2'd1;
  localparam logic [1:0] CUREQ_INV = 2'd2;
  localparam logic [2:0] SDREQ_WB  = 3'd1;

  localparam logic [2:0] ST_INVALID  = 3'd0;
  localparam logic [2:0] ST_SHARED   = 3'd1;
  localparam logic [2:0] ST_MODIFIED = 3'd3;
  localparam logic [2:0] ST_MIGRATED = 3'd4;

  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_INV     = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

  localparam bit            TO_EN  = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_L1_REQ, S_L1_WAIT, S_WB_REQ, S_WB_WAIT, S_UPDATE, S_RSP
  } state_t;

  state_t                  state, state_n;
  logic                    ready_q;
  logic [1:0]              op_q, op_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [2:0]              st_q, st_n;
  logic [NUM_L1-1:0]       vec_q, vec_n;
  logic [NUM_L1-1:0]       req_pend, req_n;
  logic [NUM_L1-1:0]       ack_pend, ack_n;
  logic                    dirty_q, dirty_n;
  logic [TO_W-1:0]         to_cnt, cnt_n;
  logic [1:0]              rsp_q, rsp_n;
  logic [NUM_L1-1:0]       hs, open_acks, acked;
  logic                    in_wait, timed_out, needs_wb;

  // ready_q is registered so sureq_ready stays low while rst_n is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_q  <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
      st_q     <= '0;
      vec_q    <= '0;
      req_pend <= '0;
      ack_pend <= '0;
      dirty_q  <= 1'b0;
      to_cnt   <= '0;
      rsp_q    <= '0;
    end else begin
      state    <= state_n;
      ready_q  <= (state_n == S_IDLE);
      op_q     <= op_n;
      addr_q   <= addr_n;
      st_q     <= st_n;
      vec_q    <= vec_n;
      req_pend <= req_n;
      ack_pend <= ack_n;
      dirty_q  <= dirty_n;
      to_cnt   <= cnt_n;
      rsp_q    <= rsp_n;
    end
  end

  always_comb begin
    state_n   = state;
    op_n      = op_q;
    addr_n    = addr_q;
    st_n      = st_q;
    vec_n     = vec_q;
    req_n     = req_pend;
    ack_n     = ack_pend;
    dirty_n   = dirty_q;
    cnt_n     = to_cnt;
    rsp_n     = rsp_q;

    sureq_ready   = 1'b0;
    tag_rd_en     = 1'b0;
    cureq_valid   = '0;
    sdreq_valid   = 1'b0;
    tag_wr_en     = 1'b0;
    tag_wr_st     = '0;
    tag_wr_l1_vec = '0;
    sursp_valid   = 1'b0;
    sursp_rsp     = '0;
    timeout_err   = 1'b0;

    tag_rd_addr = (state == S_IDLE) ? '0 : addr_q;
    cureq_addr  = (state == S_IDLE) ? '0 : addr_q;
    sdreq_addr  = (state == S_IDLE) ? '0 : addr_q;
    tag_wr_addr = (state == S_IDLE) ? '0 : addr_q;
    sdreq_op    = (state == S_IDLE) ? 3'd0 : SDREQ_WB;
    if (state == S_IDLE)
      cureq_op = 2'd0;
    else if (op_q == SUREQ_RFO && st_q == ST_MIGRATED)
      cureq_op = CUREQ_RFO;
    else if (op_q != SUREQ_RD)
      cureq_op = CUREQ_INV;
    else
      cureq_op = CUREQ_RD;

    hs        = req_pend & cureq_ready;
    open_acks = ack_pend | hs;
    acked     = open_acks & cursp_valid;
    needs_wb  = (st_q == ST_MODIFIED) || (st_q == ST_MIGRATED);
    in_wait   = (state == S_L1_REQ) || (state == S_L1_WAIT) ||
                (state == S_WB_REQ) || (state == S_WB_WAIT);
    timed_out = TO_EN && in_wait && (to_cnt == TO_LIM);

    case (state)
      S_IDLE: begin
        sureq_ready = ready_q;
        if (sureq_valid && ready_q) begin
          tag_rd_en   = 1'b1;
          tag_rd_addr = sureq_addr;
          op_n        = sureq_op;
          addr_n      = sureq_addr;
          state_n     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        st_n    = tag_rd_st;
        vec_n   = tag_rd_l1_vec;
        dirty_n = 1'b0;
        ack_n   = '0;
        cnt_n   = '0;
        if (tag_rd_st == ST_INVALID) begin
          rsp_n   = RSP_INV;
          state_n = S_RSP;
        end else if ((op_q != SUREQ_RD && tag_rd_l1_vec != '0) || tag_rd_st == ST_MIGRATED) begin
          // a migrated block with no recorded sharers must be chased on every channel
          req_n   = (tag_rd_st == ST_MIGRATED && tag_rd_l1_vec == '0) ? '1 : tag_rd_l1_vec;
          state_n = S_L1_REQ;
        end else if (tag_rd_st == ST_MODIFIED) begin
          state_n = S_WB_REQ;
        end else begin
          state_n = S_UPDATE;
        end
      end
      S_L1_REQ, S_L1_WAIT: begin
        if (timed_out) begin
          timeout_err = 1'b1;
          req_n       = '0;
          ack_n       = '0;
          rsp_n       = RSP_TIMEOUT;
          state_n     = S_RSP;
        end else begin
          cureq_valid = req_pend;
          req_n       = req_pend & ~hs;
          ack_n       = open_acks & ~cursp_valid;
          dirty_n     = dirty_q | (|(acked & cursp_dirty));
          cnt_n       = to_cnt + 1'b1;
          if (state == S_L1_REQ) begin
            if (req_n == '0)
              state_n = S_L1_WAIT;
          end else if (ack_n == '0) begin
            if (needs_wb || dirty_n) begin
              cnt_n   = '0;
              state_n = S_WB_REQ;
            end else begin
              state_n = S_UPDATE;
            end
          end
        end
      end
      S_WB_REQ: begin
        if (timed_out) begin
          timeout_err = 1'b1;
          rsp_n       = RSP_TIMEOUT;
          state_n     = S_RSP;
        end else begin
          sdreq_valid = 1'b1;
          cnt_n       = to_cnt + 1'b1;
          if (sdreq_ready)
            state_n = sdrsp_valid ? S_UPDATE : S_WB_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (timed_out) begin
          timeout_err = 1'b1;
          rsp_n       = RSP_TIMEOUT;
          state_n     = S_RSP;
        end else begin
          cnt_n = to_cnt + 1'b1;
          if (sdrsp_valid)
            state_n = S_UPDATE;
        end
      end
      S_UPDATE: begin
        tag_wr_en     = 1'b1;
        tag_wr_st     = (op_q == SUREQ_RD) ? ST_SHARED : ST_INVALID;
        tag_wr_l1_vec = (op_q == SUREQ_RD) ? vec_q : '0;
        rsp_n         = RSP_OKAY;
        state_n       = S_RSP;
      end
      S_RSP: begin
        sursp_valid = 1'b1;
        sursp_rsp   = rsp_q;
        if (sursp_ready)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_snp_req_ctrl_mc.sv
// Self-checking bench for snp_req_ctrl_mc: directed snoop scenarios with a response scoreboard
// fed at request time and drained by a monitor on each accepted snoop response.
module tb_snp_req_ctrl_mc;

  localparam logic [1:0] OP_RD = 2'd0, OP_RFO = 2'd1, OP_INV = 2'd2;
  localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_MIG = 3'd4;
  localparam logic [1:0] R_OKAY = 2'b00, R_INV = 2'b01, R_TO = 2'b10;
  localparam logic [2:0] SDREQ_WB = 3'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sureq_valid = 1'b0;
  logic        sureq_ready;
  logic [1:0]  sureq_op = '0;
  logic [31:0] sureq_addr = '0;
  logic        tag_rd_en;
  logic [31:0] tag_rd_addr;
  logic [2:0]  tag_rd_st = '0;
  logic [1:0]  tag_rd_l1_vec = '0;
  logic [1:0]  cureq_valid;
  logic [1:0]  cureq_ready = '0;
  logic [1:0]  cureq_op;
  logic [31:0] cureq_addr;
  logic [1:0]  cursp_valid = '0;
  logic [1:0]  cursp_dirty = '0;
  logic        sdreq_valid;
  logic        sdreq_ready = 1'b0;
  logic [2:0]  sdreq_op;
  logic [31:0] sdreq_addr;
  logic        sdrsp_valid = 1'b0;
  logic        tag_wr_en;
  logic [31:0] tag_wr_addr;
  logic [2:0]  tag_wr_st;
  logic [1:0]  tag_wr_l1_vec;
  logic        sursp_valid;
  logic        sursp_ready = 1'b1;
  logic [1:0]  sursp_rsp;
  logic        timeout_err;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_q[$];

  always #5 clk = ~clk;

  snp_req_ctrl_mc #(.ADDR_WIDTH(32), .NUM_L1(2), .TIMEOUT_CYC(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .sureq_valid(sureq_valid), .sureq_ready(sureq_ready), .sureq_op(sureq_op), .sureq_addr(sureq_addr),
    .tag_rd_en(tag_rd_en), .tag_rd_addr(tag_rd_addr), .tag_rd_st(tag_rd_st), .tag_rd_l1_vec(tag_rd_l1_vec),
    .cureq_valid(cureq_valid), .cureq_ready(cureq_ready), .cureq_op(cureq_op), .cureq_addr(cureq_addr),
    .cursp_valid(cursp_valid), .cursp_dirty(cursp_dirty),
    .sdreq_valid(sdreq_valid), .sdreq_ready(sdreq_ready), .sdreq_op(sdreq_op), .sdreq_addr(sdreq_addr),
    .sdrsp_valid(sdrsp_valid),
    .tag_wr_en(tag_wr_en), .tag_wr_addr(tag_wr_addr), .tag_wr_st(tag_wr_st), .tag_wr_l1_vec(tag_wr_l1_vec),
    .sursp_valid(sursp_valid), .sursp_ready(sursp_ready), .sursp_rsp(sursp_rsp), .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic idleInputs();
    cureq_ready = '0;
    cursp_valid = '0;
    cursp_dirty = '0;
    sdreq_ready = 1'b0;
    sdrsp_valid = 1'b0;
  endtask

  // Accept cycle T, then present the tag read data in the lookup cycle T+1
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [2:0] st,
                               input logic [1:0] vec, input bit push, input logic [1:0] exp_rsp);
    @(negedge clk);
    idleInputs();
    checkOutput("sureq_ready", 32'(sureq_ready), 32'd1);
    sureq_valid = 1'b1;
    sureq_op    = op;
    sureq_addr  = addr;
    #1;
    checkOutput("tag_rd_en", 32'(tag_rd_en), 32'd1);
    checkOutput("tag_rd_addr", tag_rd_addr, addr);
    if (push) exp_q.push_back(exp_rsp);
    @(negedge clk);
    sureq_valid   = 1'b0;
    tag_rd_st     = st;
    tag_rd_l1_vec = vec;
    #1;
    checkOutput("lookup_no_cureq", 32'(cureq_valid), 32'd0);
  endtask

  // Scoreboard drain: every accepted snoop response must match the oldest expectation
  always @(negedge clk) begin
    #2;
    if (rst_n && sursp_valid && sursp_ready) begin
      if (exp_q.size() == 0)
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      else
        checkOutput("sursp_rsp", 32'(sursp_rsp), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // reset state, with a request already offered
    sureq_valid = 1'b1;
    #1;
    checkOutput("rst_sureq_ready", 32'(sureq_ready), 32'd0);
    checkOutput("rst_tag_rd_en", 32'(tag_rd_en), 32'd0);
    checkOutput("rst_outputs", {tag_wr_en, sdreq_valid, sursp_valid, timeout_err, cureq_valid, sdreq_op}, 32'd0);
    sureq_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // RD miss on an INVALID block, response held one cycle by sursp_ready
    applyStimulus(OP_RD, 32'h100, ST_I, 2'b00, 1'b1, R_INV);
    @(negedge clk); sursp_ready = 1'b0; #1;
    checkOutput("t1_rsp_valid_T2", 32'(sursp_valid), 32'd1);
    checkOutput("t1_no_tag_wr", 32'(tag_wr_en | sdreq_valid), 32'd0);
    @(negedge clk); sursp_ready = 1'b1; #1;
    checkOutput("t1_rsp_held", {sursp_valid, sursp_rsp}, {1'b1, R_INV});

    // clean RD on EXCLUSIVE
    applyStimulus(OP_RD, 32'h200, ST_E, 2'b01, 1'b1, R_OKAY);
    @(negedge clk); #1;
    checkOutput("t2_tag_wr_en", 32'(tag_wr_en), 32'd1);
    checkOutput("t2_tag_wr", {tag_wr_st, tag_wr_l1_vec}, {ST_S, 2'b01});
    checkOutput("t2_tag_wr_addr", tag_wr_addr, 32'h200);
    checkOutput("t2_no_cureq", 32'(cureq_valid), 32'd0);
    @(negedge clk); #1;
    checkOutput("t2_rsp_valid_T3", 32'(sursp_valid), 32'd1);

    // INV on SHARED 11, channel 1 ready late, acks out of order
    applyStimulus(OP_INV, 32'h300, ST_S, 2'b11, 1'b1, R_OKAY);
    @(negedge clk); cureq_ready = 2'b01; #1;
    checkOutput("t3_cureq_valid", 32'(cureq_valid), 32'd3);
    checkOutput("t3_cureq_op", 32'(cureq_op), 32'(OP_INV));
    checkOutput("t3_cureq_addr", cureq_addr, 32'h300);
    @(negedge clk); cureq_ready = 2'b00; #1;
    checkOutput("t3_ch0_dropped", 32'(cureq_valid), 32'd2);
    @(negedge clk); cureq_ready = 2'b10; cursp_valid = 2'b10; #1;
    checkOutput("t3_ch1_still", 32'(cureq_valid), 32'd2);
    @(negedge clk); idleInputs(); cursp_valid = 2'b01; #1;
    checkOutput("t3_wait_no_cureq", 32'(cureq_valid), 32'd0);
    @(negedge clk); idleInputs(); #1;
    checkOutput("t3_tag_wr", {tag_wr_en, tag_wr_st, tag_wr_l1_vec}, {1'b1, ST_I, 2'b00});
    @(negedge clk); #1;
    checkOutput("t3_rsp_valid", 32'(sursp_valid), 32'd1);

    // RFO on MIGRATED 10 with dirty ack, plus a stray ack on untargeted channel 0
    applyStimulus(OP_RFO, 32'h400, ST_MIG, 2'b10, 1'b1, R_OKAY);
    @(negedge clk); cureq_ready = 2'b11; cursp_valid = 2'b01; #1;
    checkOutput("t4_cureq_valid", 32'(cureq_valid), 32'd2);
    checkOutput("t4_cureq_op", 32'(cureq_op), 32'(OP_RFO));
    @(negedge clk); idleInputs(); cursp_valid = 2'b10; cursp_dirty = 2'b10; #1;
    checkOutput("t4_wait_no_wb", 32'(sdreq_valid), 32'd0);
    @(negedge clk); idleInputs(); sdreq_ready = 1'b1; #1;
    checkOutput("t4_sdreq", {sdreq_valid, sdreq_op}, {1'b1, SDREQ_WB});
    checkOutput("t4_sdreq_addr", sdreq_addr, 32'h400);
    @(negedge clk); idleInputs(); sdrsp_valid = 1'b1; #1;
    checkOutput("t4_single_wb", 32'(sdreq_valid), 32'd0);
    @(negedge clk); idleInputs(); #1;
    checkOutput("t4_tag_wr", {tag_wr_en, tag_wr_st, tag_wr_l1_vec}, {1'b1, ST_I, 2'b00});
    @(negedge clk); #1;
    checkOutput("t4_rsp_valid", 32'(sursp_valid), 32'd1);

    // INV on clean EXCLUSIVE: dirty ack alone forces a writeback
    applyStimulus(OP_INV, 32'h500, ST_E, 2'b01, 1'b1, R_OKAY);
    @(negedge clk); cureq_ready = 2'b01; cursp_valid = 2'b01; cursp_dirty = 2'b01; #1;
    checkOutput("t5_cureq_valid", 32'(cureq_valid), 32'd1);
    @(negedge clk); idleInputs(); #1;
    checkOutput("t5_wait", {cureq_valid, sdreq_valid, tag_wr_en}, 32'd0);
    @(negedge clk); sdreq_ready = 1'b1; sdrsp_valid = 1'b1; #1;
    checkOutput("t5_dirty_wb", 32'(sdreq_valid), 32'd1);
    @(negedge clk); idleInputs(); #1;
    checkOutput("t5_tag_wr", {tag_wr_en, tag_wr_st}, {1'b1, ST_I});
    @(negedge clk); #1;

    // RD on MIGRATED with empty vector broadcasts to all channels
    applyStimulus(OP_RD, 32'h580, ST_MIG, 2'b00, 1'b1, R_OKAY);
    @(negedge clk); cureq_ready = 2'b11; cursp_valid = 2'b11; #1;
    checkOutput("t6_broadcast", {cureq_valid, cureq_op}, {2'b11, OP_RD});
    @(negedge clk); idleInputs(); #1;
    @(negedge clk); sdreq_ready = 1'b1; sdrsp_valid = 1'b1; #1;
    checkOutput("t6_wb", 32'(sdreq_valid), 32'd1);
    @(negedge clk); idleInputs(); #1;
    checkOutput("t6_tag_wr", {tag_wr_en, tag_wr_st, tag_wr_l1_vec}, {1'b1, ST_S, 2'b00});
    @(negedge clk); #1;

    // RD on MODIFIED, writeback response never arrives: timeout after 4 cycles
    applyStimulus(OP_RD, 32'h600, ST_M, 2'b01, 1'b1, R_TO);
    @(negedge clk); sdreq_ready = 1'b1; #1;
    checkOutput("t7_sdreq", 32'(sdreq_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idleInputs(); #1;
      checkOutput("t7_no_early_to", 32'(timeout_err | sdreq_valid), 32'd0);
    end
    @(negedge clk); #1;
    checkOutput("t7_timeout_err", 32'(timeout_err), 32'd1);
    checkOutput("t7_no_tag_wr", 32'(tag_wr_en), 32'd0);
    @(negedge clk); #1;
    checkOutput("t7_rsp_state", {sursp_valid, timeout_err}, {1'b1, 1'b0});
    @(negedge clk); sdrsp_valid = 1'b1; #1;
    checkOutput("t7_late_sdrsp", {sursp_valid, tag_wr_en}, 32'd0);

    // next request after the abort is handled normally
    applyStimulus(OP_RD, 32'h700, ST_I, 2'b00, 1'b1, R_INV);
    @(negedge clk); #1;
    checkOutput("t8_rsp_valid", 32'(sursp_valid), 32'd1);

    // reset asserted while waiting for L1 acks abandons the transaction
    applyStimulus(OP_INV, 32'h800, ST_S, 2'b01, 1'b0, R_OKAY);
    @(negedge clk); cureq_ready = 2'b01; #1;
    @(negedge clk); idleInputs(); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t9_async_rst", {sureq_ready, cureq_valid, sdreq_valid, tag_wr_en, sursp_valid}, 32'd0);
    checkOutput("t9_rst_addr", cureq_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); cursp_valid = 2'b01; #1;
    checkOutput("t9_ready_after", 32'(sureq_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idleInputs(); #1;
      checkOutput("t9_no_rsp", {sursp_valid, tag_wr_en}, 32'd0);
    end

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
